// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous data-memory port between the core load/store path
// (port C) and an external debug/DMA master (port D). Each access goes
// through IDLE -> ACCESS -> [WAIT] -> RESP, with one access in flight at a
// time. The core is stalled combinationally until its own access completes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   c_req/c_we/c_addr/
//   c_wdata/c_wmask          core command, held stable until c_done
//   c_stall                  c_req & ~c_done
//   c_done, c_rdata          one-cycle completion pulse, load data with it
//   d_req/d_we/d_addr/
//   d_wdata/d_wmask          external master command, held until d_done
//   d_done, d_rdata          one-cycle completion pulse, load data with it
//   m_en/m_we/m_addr/
//   m_wdata/m_wmask          RAM strobe and command, non-zero only in ACCESS
//   m_rdata                  RAM read data, valid LAT cycles after m_en
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            c_req,
   input  logic            c_we,
   input  logic [AW-1:0]   c_addr,
   input  logic [DW-1:0]   c_wdata,
   input  logic [DW/8-1:0] c_wmask,
   output logic            c_stall,
   output logic            c_done,
   output logic [DW-1:0]   c_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wmask,
   output logic            d_done,
   output logic [DW-1:0]   d_rdata,
   output logic            m_en,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_wmask,
   input  logic [DW-1:0]   m_rdata
);

   localparam int MW = DW / 8;
   localparam logic OWN_C = 1'b0;
   localparam logic OWN_D = 1'b1;
   localparam logic [2:0] LAST_WAIT = 3'(LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      wait_cnt;
   logic [2:0]      wait_cnt_nxt;
   logic            last_owner;
   logic            owner;
   logic            accept;
   logic            pick_d;
   logic            capture;
   logic            cmd_we;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [MW-1:0]   cmd_wmask;
   logic [DW-1:0]   rdata_q;

   // Next-state and grant decision. On a tie the port that did not own the
   // previous access wins; last_owner resets to D so the core wins the first
   // tie after reset.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      accept       = 1'b0;
      pick_d       = 1'b0;
      case (state)
         S_IDLE: begin
            if (c_req || d_req) begin
               accept    = 1'b1;
               pick_d    = d_req && (!c_req || (last_owner == OWN_C));
               state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            wait_cnt_nxt = '0;
            state_nxt    = cmd_we ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt == LAST_WAIT) begin
               state_nxt = S_RESP;
            end else begin
               wait_cnt_nxt = wait_cnt + 3'd1;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign capture = (state == S_WAIT) && (wait_cnt == LAST_WAIT);

   // State, latched command and captured read data. The read-data register
   // is cleared on every grant so a write responds with zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         last_owner <= OWN_D;
         owner      <= OWN_C;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         cmd_wmask  <= '0;
         rdata_q    <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept) begin
            owner     <= pick_d;
            cmd_we    <= pick_d ? d_we    : c_we;
            cmd_addr  <= pick_d ? d_addr  : c_addr;
            cmd_wdata <= pick_d ? d_wdata : c_wdata;
            cmd_wmask <= pick_d ? d_wmask : c_wmask;
            rdata_q   <= '0;
         end
         if (capture) begin
            rdata_q <= m_rdata;
         end
         if (state == S_RESP) begin
            last_owner <= owner;
         end
      end
   end

   // Outputs decode straight from the state register, so an asynchronous
   // reset drops m_en and both done pulses immediately.
   always_comb begin
      m_en    = (state == S_ACCESS);
      m_we    = m_en && cmd_we;
      m_addr  = m_en ? cmd_addr  : '0;
      m_wdata = m_en ? cmd_wdata : '0;
      m_wmask = m_en ? cmd_wmask : '0;
      c_done  = (state == S_RESP) && (owner == OWN_C);
      d_done  = (state == S_RESP) && (owner == OWN_D);
      c_rdata = c_done ? rdata_q : '0;
      d_rdata = d_done ? rdata_q : '0;
      c_stall = c_req && !c_done;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Two arbiter instances (LAT=1 and LAT=3), each with its own behavioural
// RAM. Expected latencies, grant order and load data come from a reference
// model: a per-instance word array updated from issued stores plus a
// round-robin owner variable.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int MW    = DW / 8;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [MW-1:0] wmask;
   } cmd_t;

   logic clk = 1'b0;
   logic rst;
   logic ram_clr;

   logic          c_req[2], c_we[2], d_req[2], d_we[2];
   logic [AW-1:0] c_addr[2], d_addr[2], m_addr[2];
   logic [DW-1:0] c_wdata[2], d_wdata[2], m_wdata[2], m_rdata[2];
   logic [MW-1:0] c_wmask[2], d_wmask[2], m_wmask[2];
   logic          c_stall[2], c_done[2], d_done[2], m_en[2], m_we[2];
   logic [DW-1:0] c_rdata[2], d_rdata[2];

   logic [DW-1:0] ram[2][256];
   logic [DW-1:0] pipe[2][4];
   logic [DW-1:0] ref_mem[2][256];
   logic          tb_last[2];

   int checks;
   int passed;

   int            r_ck, r_dk, r_men_k, r_b2b, r_stall, r_spur;
   logic [DW-1:0] r_crd, r_drd, r_maddr, r_mdata;
   logic          r_mwe;
   logic [MW-1:0] r_mmask;

   // Free-running clock.
   always #5 clk = ~clk;

   // Two devices under test sharing clock and reset, differing only in LAT.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int L = (g == 0) ? LAT_A : LAT_B;
      dmem_arbiter #(.AW(AW), .DW(DW), .LAT(L)) u_dut (
         .clk(clk), .rst(rst),
         .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]),
         .c_wdata(c_wdata[g]), .c_wmask(c_wmask[g]),
         .c_stall(c_stall[g]), .c_done(c_done[g]), .c_rdata(c_rdata[g]),
         .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]),
         .d_wdata(d_wdata[g]), .d_wmask(d_wmask[g]),
         .d_done(d_done[g]), .d_rdata(d_rdata[g]),
         .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]),
         .m_wdata(m_wdata[g]), .m_wmask(m_wmask[g]), .m_rdata(m_rdata[g])
      );
      assign m_rdata[g] = pipe[g][L-1];
   end

   // Behavioural synchronous RAM per instance. Read data travels down a
   // pipeline so it is valid exactly LAT cycles after the m_en cycle; any
   // non-read slot carries a poison pattern.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         for (int s = 3; s > 0; s--) pipe[i][s] <= pipe[i][s-1];
         pipe[i][0] <= (m_en[i] && !m_we[i]) ? ram[i][m_addr[i][9:2]] : 32'hBAD0_BAD0;
         if (ram_clr) begin
            for (int w = 0; w < 256; w++) ram[i][w] <= '0;
         end else if (m_en[i] && m_we[i]) begin
            for (int b = 0; b < MW; b++)
               if (m_wmask[i][b]) ram[i][m_addr[i][9:2]][8*b +: 8] <= m_wdata[i][8*b +: 8];
         end
      end
   end

   function automatic cmd_t mk(input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic [MW-1:0] m);
      return {we, a, wd, m};
   endfunction

   task automatic apply_ref(input int i, input cmd_t c);
      if (c.we)
         for (int b = 0; b < MW; b++)
            if (c.wmask[b]) ref_mem[i][c.addr[9:2]][8*b +: 8] = c.wdata[8*b +: 8];
   endtask

   // Drives the selected ports, drops each request on its own done and
   // records completion cycles (k=0 is the cycle the request is first seen),
   // load data, first RAM command and protocol oddities.
   task automatic run_ops(input int i, input bit use_c, input cmd_t cc,
                          input bit use_d, input cmd_t dc, input bit fresh);
      bit prev = 1'b0;
      r_ck = -1; r_dk = -1; r_men_k = -1; r_b2b = 0; r_stall = 0; r_spur = 0;
      r_crd = '0; r_drd = '0; r_maddr = '0; r_mdata = '0; r_mwe = 1'b0; r_mmask = '0;
      if (fresh) @(negedge clk);
      if (use_c) begin
         c_req[i] = 1'b1;
         {c_we[i], c_addr[i], c_wdata[i], c_wmask[i]} = cc;
      end
      if (use_d) begin
         d_req[i] = 1'b1;
         {d_we[i], d_addr[i], d_wdata[i], d_wmask[i]} = dc;
      end
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (c_stall[i]) r_stall++;
         if (m_en[i]) begin
            if (prev) r_b2b++;
            if (r_men_k < 0) begin
               r_men_k = k; r_mwe = m_we[i]; r_mmask = m_wmask[i];
               r_maddr = m_addr[i]; r_mdata = m_wdata[i];
            end
         end
         prev = m_en[i];
         if (c_done[i]) begin
            if (c_req[i] && r_ck < 0) begin
               r_ck = k; r_crd = c_rdata[i]; c_req[i] = 1'b0;
            end else r_spur++;
         end
         if (d_done[i]) begin
            if (d_req[i] && r_dk < 0) begin
               r_dk = k; r_drd = d_rdata[i]; d_req[i] = 1'b0;
            end else r_spur++;
         end
         if ((!use_c || r_ck >= 0) && (!use_d || r_dk >= 0)) break;
      end
      c_req[i] = 1'b0;
      d_req[i] = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         checks++; if ({m_en[i], m_we[i], m_addr[i], m_wdata[i], m_wmask[i]} !== '0)
            $display("[TB] FAIL reset_m_outputs inst%0d got en=%b addr=%h want all 0", i, m_en[i], m_addr[i]); else passed++;
         checks++; if ({c_done[i], d_done[i], c_rdata[i], d_rdata[i]} !== '0)
            $display("[TB] FAIL reset_done_rdata inst%0d got c_done=%b d_done=%b want all 0", i, c_done[i], d_done[i]); else passed++;
      end
      c_req[0] = 1'b1;
      @(negedge clk); #1;
      checks++; if (m_en[0] !== 1'b0) $display("[TB] FAIL reset_hold_men got %b want 0", m_en[0]); else passed++;
      checks++; if (c_stall[0] !== 1'b1) $display("[TB] FAIL reset_stall got %b want 1", c_stall[0]); else passed++;
      c_req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tb_last[0] = 1'b1; tb_last[1] = 1'b1;
   endtask

   task automatic test_store();
      cmd_t c = mk(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      run_ops(0, 1'b1, c, 1'b0, '0, 1'b1);
      checks++; if (r_ck !== 2) $display("[TB] FAIL store_done_cycle got %0d want 2", r_ck); else passed++;
      checks++; if (r_men_k !== 1 || r_mwe !== 1'b1) $display("[TB] FAIL store_men got k=%0d we=%b want k=1 we=1", r_men_k, r_mwe); else passed++;
      checks++; if ({r_maddr, r_mdata} !== {32'h10, 32'hDEAD_BEEF}) $display("[TB] FAIL store_m_cmd got %h/%h want 10/deadbeef", r_maddr, r_mdata); else passed++;
      checks++; if (r_stall !== 2) $display("[TB] FAIL store_stall got %0d want 2", r_stall); else passed++;
      apply_ref(0, c);
      tb_last[0] = 1'b0;
   endtask

   task automatic test_load();
      logic [DW-1:0] exp = ref_mem[0][8'h04];
      run_ops(0, 1'b1, mk(1'b0, 32'h10, '0, '0), 1'b0, '0, 1'b1);
      checks++; if (r_ck !== 2 + LAT_A) $display("[TB] FAIL load_done_cycle got %0d want %0d", r_ck, 2 + LAT_A); else passed++;
      checks++; if (r_men_k !== 1 || r_mwe !== 1'b0) $display("[TB] FAIL load_men got k=%0d we=%b want k=1 we=0", r_men_k, r_mwe); else passed++;
      checks++; if (r_crd !== exp) $display("[TB] FAIL load_rdata got %h want %h", r_crd, exp); else passed++;
      checks++; if (r_spur !== 0) $display("[TB] FAIL load_spurious_done got %0d want 0", r_spur); else passed++;
      checks++; if (r_stall !== 2 + LAT_A) $display("[TB] FAIL load_stall got %0d want %0d", r_stall, 2 + LAT_A); else passed++;
      tb_last[0] = 1'b0;
   endtask

   task automatic test_byte_store();
      cmd_t d = mk(1'b1, 32'h20, 32'h0000_AB00, 4'b0010);
      run_ops(0, 1'b0, '0, 1'b1, d, 1'b1);
      checks++; if (r_dk !== 2) $display("[TB] FAIL byte_store_done got %0d want 2", r_dk); else passed++;
      checks++; if (r_mmask !== 4'b0010) $display("[TB] FAIL byte_store_mask got %b want 0010", r_mmask); else passed++;
      apply_ref(0, d);
      run_ops(0, 1'b1, mk(1'b0, 32'h20, '0, '0), 1'b0, '0, 1'b1);
      checks++; if (r_crd[15:8] !== 8'hAB) $display("[TB] FAIL byte_load_byte1 got %h want ab", r_crd[15:8]); else passed++;
      checks++; if (r_crd !== ref_mem[0][8'h08]) $display("[TB] FAIL byte_load_word got %h want %h", r_crd, ref_mem[0][8'h08]); else passed++;
      tb_last[0] = 1'b0;
   endtask

   task automatic test_round_robin();
      int ord[8], kd[8];
      logic [DW-1:0] rds[8];
      int n = 0;
      int b2b = 0;
      bit prev = 1'b0;
      logic [DW-1:0] exp_c = ref_mem[0][8'h04];
      logic [DW-1:0] exp_d = ref_mem[0][8'h08];
      @(negedge clk);
      rst = 1'b1;
      c_req[0] = 1'b1; {c_we[0], c_addr[0], c_wdata[0], c_wmask[0]} = mk(1'b0, 32'h10, '0, '0);
      d_req[0] = 1'b1; {d_we[0], d_addr[0], d_wdata[0], d_wmask[0]} = mk(1'b0, 32'h20, '0, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 40 && n < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (m_en[0] && prev) b2b++;
         prev = m_en[0];
         if (c_done[0] && n < 8) begin ord[n] = 0; kd[n] = k; rds[n] = c_rdata[0]; n++; end
         if (d_done[0] && n < 8) begin ord[n] = 1; kd[n] = k; rds[n] = d_rdata[0]; n++; end
      end
      c_req[0] = 1'b0; d_req[0] = 1'b0;
      checks++; if (n !== 4) $display("[TB] FAIL rr_count got %0d want 4", n); else passed++;
      for (int j = 0; j < n && j < 4; j++) begin
         checks++; if (ord[j] !== j % 2) $display("[TB] FAIL rr_order[%0d] got %0d want %0d", j, ord[j], j % 2); else passed++;
         checks++; if (kd[j] !== (2 + LAT_A) + j * (3 + LAT_A))
            $display("[TB] FAIL rr_cycle[%0d] got %0d want %0d", j, kd[j], (2 + LAT_A) + j * (3 + LAT_A)); else passed++;
         checks++; if (rds[j] !== ((j % 2) ? exp_d : exp_c))
            $display("[TB] FAIL rr_rdata[%0d] got %h want %h", j, rds[j], (j % 2) ? exp_d : exp_c); else passed++;
      end
      checks++; if (b2b !== 0) $display("[TB] FAIL rr_back_to_back_men got %0d want 0", b2b); else passed++;
      @(negedge clk);
      tb_last[0] = 1'b1; tb_last[1] = 1'b1;
   endtask

   task automatic test_reset_mid_access();
      cmd_t st = mk(1'b1, 32'h30, 32'h1234_5678, 4'hF);
      cmd_t cl = mk(1'b0, 32'h30, '0, '0);
      cmd_t dl = mk(1'b0, 32'h34, '0, '0);
      int spur = 0;
      run_ops(1, 1'b1, st, 1'b0, '0, 1'b1);
      apply_ref(1, st);
      @(negedge clk);
      c_req[1] = 1'b1; {c_we[1], c_addr[1], c_wdata[1], c_wmask[1]} = cl;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 2) begin
            d_req[1] = 1'b1; {d_we[1], d_addr[1], d_wdata[1], d_wmask[1]} = dl;
         end
         #1;
         if (c_done[1] || d_done[1]) spur++;
      end
      rst = 1'b1;
      #1;
      checks++; if ({m_en[1], c_done[1], d_done[1]} !== 3'b000)
         $display("[TB] FAIL midreset_outputs got en=%b c=%b d=%b want 000", m_en[1], c_done[1], d_done[1]); else passed++;
      repeat (2) begin
         @(negedge clk); #1;
         if (c_done[1] || d_done[1]) spur++;
      end
      checks++; if (spur !== 0) $display("[TB] FAIL midreset_no_done got %0d want 0", spur); else passed++;
      @(negedge clk);
      rst = 1'b0;
      tb_last[0] = 1'b1; tb_last[1] = 1'b1;
      run_ops(1, 1'b1, cl, 1'b1, dl, 1'b0);
      checks++; if (r_men_k !== 1) $display("[TB] FAIL midreset_regrant got %0d want 1", r_men_k); else passed++;
      checks++; if (r_ck !== 2 + LAT_B) $display("[TB] FAIL midreset_c_done got %0d want %0d", r_ck, 2 + LAT_B); else passed++;
      checks++; if (r_crd !== 32'h1234_5678) $display("[TB] FAIL midreset_c_rdata got %h want 12345678", r_crd); else passed++;
      checks++; if (r_dk !== 2 * (2 + LAT_B) + 1) $display("[TB] FAIL midreset_d_done got %0d want %0d", r_dk, 2 * (2 + LAT_B) + 1); else passed++;
      checks++; if (r_drd !== ref_mem[1][8'h0D]) $display("[TB] FAIL midreset_d_rdata got %h want %h", r_drd, ref_mem[1][8'h0D]); else passed++;
      tb_last[1] = 1'b1;
   endtask

   task automatic test_async_abort();
      @(negedge clk);
      c_req[0] = 1'b1; {c_we[0], c_addr[0], c_wdata[0], c_wmask[0]} = mk(1'b0, 32'h10, '0, '0);
      @(negedge clk); #1;
      checks++; if (m_en[0] !== 1'b1) $display("[TB] FAIL abort_access_men got %b want 1", m_en[0]); else passed++;
      rst = 1'b1;
      #1;
      checks++; if ({m_en[0], m_addr[0]} !== '0) $display("[TB] FAIL abort_async_men got en=%b addr=%h want 0", m_en[0], m_addr[0]); else passed++;
      c_req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tb_last[0] = 1'b1; tb_last[1] = 1'b1;
   endtask

   task automatic test_pulse_ignored();
      int ck = -1;
      int men = 0;
      int dd = 0;
      @(negedge clk);
      c_req[0] = 1'b1; {c_we[0], c_addr[0], c_wdata[0], c_wmask[0]} = mk(1'b0, 32'h20, '0, '0);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 2) begin
            d_req[0] = 1'b1; {d_we[0], d_addr[0], d_wdata[0], d_wmask[0]} = mk(1'b1, 32'h40, 32'h5555_AAAA, 4'hF);
         end
         if (k == 3) d_req[0] = 1'b0;
         #1;
         if (m_en[0]) men++;
         if (d_done[0]) dd++;
         if (c_done[0] && ck < 0) begin ck = k; c_req[0] = 1'b0; end
      end
      checks++; if (ck !== 2 + LAT_A) $display("[TB] FAIL pulse_core_done got %0d want %0d", ck, 2 + LAT_A); else passed++;
      checks++; if (dd !== 0) $display("[TB] FAIL pulse_d_done got %0d want 0", dd); else passed++;
      checks++; if (men !== 1) $display("[TB] FAIL pulse_men_count got %0d want 1", men); else passed++;
      tb_last[0] = 1'b0;
   endtask

   task automatic test_random();
      int i, lat, sc, sd, ek_c, ek_d, mode;
      bit use_c, use_d;
      cmd_t cc, dc;
      logic [DW-1:0] erc, erd;
      for (int it = 0; it < 16; it++) begin
         i = it % 2;
         lat = (i == 0) ? LAT_A : LAT_B;
         mode = $urandom_range(0, 2);
         use_c = (mode != 1);
         use_d = (mode != 0);
         cc = mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom, 4'($urandom_range(1, 15)));
         dc = mk(1'($urandom_range(0, 1)), 32'($urandom_range(64, 127)) << 2, $urandom, 4'($urandom_range(1, 15)));
         sc = cc.we ? 2 : 2 + lat;
         sd = dc.we ? 2 : 2 + lat;
         ek_c = -1; ek_d = -1;
         if (use_c && use_d) begin
            if (tb_last[i]) begin ek_c = sc; ek_d = sc + 1 + sd; tb_last[i] = 1'b1; end
            else begin ek_d = sd; ek_c = sd + 1 + sc; tb_last[i] = 1'b0; end
         end else if (use_c) begin ek_c = sc; tb_last[i] = 1'b0; end
         else begin ek_d = sd; tb_last[i] = 1'b1; end
         erc = (use_c && !cc.we) ? ref_mem[i][cc.addr[9:2]] : '0;
         erd = (use_d && !dc.we) ? ref_mem[i][dc.addr[9:2]] : '0;
         run_ops(i, use_c, cc, use_d, dc, 1'b1);
         checks++; if (r_ck !== ek_c) $display("[TB] FAIL rnd%0d_c_done got %0d want %0d", it, r_ck, ek_c); else passed++;
         checks++; if (r_dk !== ek_d) $display("[TB] FAIL rnd%0d_d_done got %0d want %0d", it, r_dk, ek_d); else passed++;
         checks++; if (r_crd !== erc) $display("[TB] FAIL rnd%0d_c_rdata got %h want %h", it, r_crd, erc); else passed++;
         checks++; if (r_drd !== erd) $display("[TB] FAIL rnd%0d_d_rdata got %h want %h", it, r_drd, erd); else passed++;
         checks++; if (r_stall !== (use_c ? ek_c : 0)) $display("[TB] FAIL rnd%0d_stall got %0d want %0d", it, r_stall, use_c ? ek_c : 0); else passed++;
         checks++; if (r_spur + r_b2b !== 0) $display("[TB] FAIL rnd%0d_protocol got spur=%0d b2b=%0d want 0", it, r_spur, r_b2b); else passed++;
         if (use_c) apply_ref(i, cc);
         if (use_d) apply_ref(i, dc);
      end
   endtask

   // Test sequence.
   initial begin
      checks = 0;
      passed = 0;
      rst = 1'b1;
      ram_clr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0; c_wmask[i] = '0;
         d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0; d_wmask[i] = '0;
         tb_last[i] = 1'b1;
         for (int w = 0; w < 256; w++) ref_mem[i][w] = '0;
      end
      repeat (2) @(negedge clk);
      ram_clr = 1'b0;
      #1;
      test_reset();
      test_store();
      test_load();
      test_byte_store();
      test_round_robin();
      test_reset_mid_access();
      test_async_abort();
      test_pulse_ignored();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
